// File: rtl/i2c_request_arbiter.sv
// i2c_request_arbiter: shares one I2C master -> result capture -> UART report
// path between decoded PC commands and a periodic temperature poll. Only one
// transaction is in flight at a time. The next grant waits for tx_complete.
//
// Build option: define AUTO_POLL_EN to include the poll counter, the poll flag
// and round-robin arbitration. Without it, only PC commands are served.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a pending request; grant latches the command
// ISSUE    | i2c_start pulse, timeout counter loaded
// WAIT     | waiting for i2c_done or the timeout terminal count
// REPORT   | data_ready pulse with toPC_* valid
// TXWAIT   | waiting for the packet transmitter to finish

module i2c_request_arbiter #(
    parameter int unsigned POLL_PERIOD    = 50_000_000,
    parameter logic [7:0]  POLL_ADDR      = 8'h00,
    parameter logic [7:0]  POLL_MODE      = 8'h01,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_req,
    output logic        pc_ready,
    input  logic [7:0]  pc_address,
    input  logic [7:0]  pc_mode,
    input  logic [15:0] pc_wdata,
    output logic        i2c_start,
    output logic [7:0]  i2c_address,
    output logic [7:0]  i2c_mode,
    output logic [15:0] i2c_wdata,
    input  logic        i2c_done,
    input  logic [15:0] i2c_rdata,
    input  logic        i2c_ack_error,
    output logic        data_ready,
    output logic [7:0]  toPC_address,
    output logic [7:0]  toPC_mode,
    output logic [15:0] toPC_data,
    input  logic        tx_complete
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_REPORT = 3'd3;
    localparam logic [2:0] S_TXWAIT = 3'd4;

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    if (POLL_PERIOD == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("i2c_request_arbiter: POLL_PERIOD and TIMEOUT_CYCLES must be nonzero");
    end

    logic [2:0]    state_q, state_d;
    logic          buf_valid_q, buf_valid_d;
    logic [7:0]    buf_addr_q, buf_addr_d;
    logic [1:0]    buf_op_q, buf_op_d;
    logic [15:0]   buf_wdata_q, buf_wdata_d;
    logic          pc_ready_q, pc_ready_d;
    logic          last_poll_q, last_poll_d;
    logic          src_poll_q, src_poll_d;
    logic [7:0]    i2c_addr_q, i2c_addr_d;
    logic [7:0]    i2c_mode_q, i2c_mode_d;
    logic [15:0]   i2c_wdata_q, i2c_wdata_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]    rpt_addr_q, rpt_addr_d;
    logic [7:0]    rpt_mode_q, rpt_mode_d;
    logic [15:0]   rpt_data_q, rpt_data_d;

    logic poll_pending;
    logic grant_pc, grant_poll;
    logic accept;
    logic is_read;
    logic unused_mode_bits;

    // Only the op field of the PC mode byte carries meaning.
    assign unused_mode_bits = ^pc_mode[7:2];

`ifdef AUTO_POLL_EN
    localparam int unsigned PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);

    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic          poll_flag_q, poll_flag_d;
    logic          poll_wrap;

    // Free-running poll counter; the flag saturates, so repeated wraps collapse.
    always_comb begin
        poll_wrap   = (poll_cnt_q == POLL_LAST);
        poll_cnt_d  = poll_wrap ? '0 : poll_cnt_q + 1'b1;
        poll_flag_d = (poll_flag_q && !grant_poll) || poll_wrap;
    end

    // Poll counter and request flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            poll_cnt_q  <= '0;
            poll_flag_q <= 1'b0;
        end else begin
            poll_cnt_q  <= poll_cnt_d;
            poll_flag_q <= poll_flag_d;
        end
    end

    assign poll_pending = poll_flag_q;
`else
    assign poll_pending = 1'b0;
`endif

    // Round-robin between the two requesters; contested grants go to the one
    // not served last.
    always_comb begin
        grant_pc   = 1'b0;
        grant_poll = 1'b0;
        if (state_q == S_IDLE) begin
            if (poll_pending && !(buf_valid_q && last_poll_q)) begin
                grant_poll = 1'b1;
            end else if (buf_valid_q) begin
                grant_pc = 1'b1;
            end
        end
    end

    // Single-entry PC command buffer; accepts in any state while empty.
    always_comb begin
        accept      = pc_req && pc_ready_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_op_d    = buf_op_q;
        buf_wdata_d = buf_wdata_q;
        if (grant_pc) begin
            buf_valid_d = 1'b0;
        end
        if (accept) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = pc_address;
            buf_op_d    = pc_mode[1:0];
            buf_wdata_d = pc_wdata;
        end
        pc_ready_d = !buf_valid_d;
    end

    // Transaction sequencing, timeout down-counter and report capture.
    always_comb begin
        state_d     = state_q;
        last_poll_d = last_poll_q;
        src_poll_d  = src_poll_q;
        i2c_addr_d  = i2c_addr_q;
        i2c_mode_d  = i2c_mode_q;
        i2c_wdata_d = i2c_wdata_q;
        tmo_cnt_d   = tmo_cnt_q;
        rpt_addr_d  = rpt_addr_q;
        rpt_mode_d  = rpt_mode_q;
        rpt_data_d  = rpt_data_q;
        is_read     = !i2c_mode_q[1];
        case (state_q)
            S_IDLE: begin
                if (grant_pc || grant_poll) begin
                    state_d     = S_ISSUE;
                    src_poll_d  = grant_poll;
                    last_poll_d = grant_poll;
                    if (grant_poll) begin
                        i2c_addr_d  = POLL_ADDR;
                        i2c_mode_d  = POLL_MODE;
                        i2c_wdata_d = 16'h0000;
                    end else begin
                        i2c_addr_d  = buf_addr_q;
                        i2c_mode_d  = {6'b000000, buf_op_q};
                        i2c_wdata_d = buf_wdata_q;
                    end
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = TMO_LOAD;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the terminal-count cycle still counts as done.
                if (i2c_done) begin
                    state_d    = S_REPORT;
                    rpt_addr_d = i2c_addr_q;
                    rpt_mode_d = {i2c_ack_error, 1'b0, src_poll_q, 3'b000, i2c_mode_q[1:0]};
                    rpt_data_d = 16'h0000;
                    if (is_read && !i2c_ack_error) begin
                        rpt_data_d = i2c_mode_q[0] ? i2c_rdata : {8'h00, i2c_rdata[7:0]};
                    end
                end else if (tmo_cnt_q == '0) begin
                    state_d    = S_REPORT;
                    rpt_addr_d = i2c_addr_q;
                    rpt_mode_d = {1'b0, 1'b1, src_poll_q, 3'b000, i2c_mode_q[1:0]};
                    rpt_data_d = 16'h0000;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end
            S_REPORT: begin
                state_d = S_TXWAIT;
            end
            S_TXWAIT: begin
                if (tx_complete) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All datapath and control registers; reset drops any buffered command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= 8'h00;
            buf_op_q    <= 2'b00;
            buf_wdata_q <= 16'h0000;
            pc_ready_q  <= 1'b1;
            last_poll_q <= 1'b1;
            src_poll_q  <= 1'b0;
            i2c_addr_q  <= 8'h00;
            i2c_mode_q  <= 8'h00;
            i2c_wdata_q <= 16'h0000;
            tmo_cnt_q   <= '0;
            rpt_addr_q  <= 8'h00;
            rpt_mode_q  <= 8'h00;
            rpt_data_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_op_q    <= buf_op_d;
            buf_wdata_q <= buf_wdata_d;
            pc_ready_q  <= pc_ready_d;
            last_poll_q <= last_poll_d;
            src_poll_q  <= src_poll_d;
            i2c_addr_q  <= i2c_addr_d;
            i2c_mode_q  <= i2c_mode_d;
            i2c_wdata_q <= i2c_wdata_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rpt_addr_q  <= rpt_addr_d;
            rpt_mode_q  <= rpt_mode_d;
            rpt_data_q  <= rpt_data_d;
        end
    end

    // Pulses are suppressed in a reset cycle even if the state says otherwise.
    assign i2c_start    = (state_q == S_ISSUE) && !reset;
    assign data_ready   = (state_q == S_REPORT) && !reset;
    assign pc_ready     = pc_ready_q;
    assign i2c_address  = i2c_addr_q;
    assign i2c_mode     = i2c_mode_q;
    assign i2c_wdata    = i2c_wdata_q;
    assign toPC_address = rpt_addr_q;
    assign toPC_mode    = rpt_mode_q;
    assign toPC_data    = rpt_data_q;

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// Testbench for i2c_request_arbiter: random PC commands, I2C responses and
// transmitter handshakes, checked against a transaction-level reference model.
// Honours AUTO_POLL_EN the same way the design does.

module tb_i2c_request_arbiter;

    localparam int P    = 100;
    localparam int TMO  = 16;
    localparam int NCYC = 20000;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  mode;
        logic [15:0] wdata;
    } cmd_t;

    typedef struct {
        int          k;
        logic [15:0] rdata;
        logic        ack;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_req;
    logic        pc_ready;
    logic [7:0]  pc_address;
    logic [7:0]  pc_mode;
    logic [15:0] pc_wdata;
    logic        i2c_start;
    logic [7:0]  i2c_address;
    logic [7:0]  i2c_mode;
    logic [15:0] i2c_wdata;
    logic        i2c_done;
    logic [15:0] i2c_rdata;
    logic        i2c_ack_error;
    logic        data_ready;
    logic [7:0]  toPC_address;
    logic [7:0]  toPC_mode;
    logic [15:0] toPC_data;
    logic        tx_complete;

    always #5 clk = ~clk;

    i2c_request_arbiter #(
        .POLL_PERIOD   (P),
        .POLL_ADDR     (8'h00),
        .POLL_MODE     (8'h01),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_req       (pc_req),
        .pc_ready     (pc_ready),
        .pc_address   (pc_address),
        .pc_mode      (pc_mode),
        .pc_wdata     (pc_wdata),
        .i2c_start    (i2c_start),
        .i2c_address  (i2c_address),
        .i2c_mode     (i2c_mode),
        .i2c_wdata    (i2c_wdata),
        .i2c_done     (i2c_done),
        .i2c_rdata    (i2c_rdata),
        .i2c_ack_error(i2c_ack_error),
        .data_ready   (data_ready),
        .toPC_address (toPC_address),
        .toPC_mode    (toPC_mode),
        .toPC_data    (toPC_data),
        .tx_complete  (tx_complete)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    cmd_t        cmdq[$];
    resp_t       respq[$];
    bit          m_buf_valid;
    cmd_t        m_buf;
    bit          m_flag;
    int          r;
    bit          m_last_poll;
    bit          m_busy;
    int          start_at;
    int          report_at;
    bit          m_src_poll;
    logic [7:0]  m_addr;
    logic [7:0]  m_mode;
    logic [15:0] m_wdata;
    logic [7:0]  e_toaddr;
    logic [7:0]  e_tomode;
    logic [15:0] e_todata;
    resp_t       cur_resp;
    int          tx_k;
    bit          post_rst;
    bit          pc_hold;
    bit          force_tx;
    bit          want_rst_wait;
    bit          want_rst_tx;

    task automatic model_reset();
        m_buf_valid = 1'b0;
        m_flag      = 1'b0;
        r           = 0;
        m_last_poll = 1'b1;
        m_busy      = 1'b0;
        start_at    = -1;
        report_at   = -1;
    endtask

    function automatic resp_t rand_resp();
        resp_t x;
        int    sel;
        sel     = int'($urandom_range(0, 9));
        x.k     = (sel < 7) ? int'($urandom_range(1, 15)) : int'($urandom_range(16, 18));
        x.rdata = 16'($urandom);
        x.ack   = ($urandom_range(0, 3) == 0);
        return x;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.addr  = 8'($urandom);
        c.mode  = 8'($urandom);
        c.wdata = 16'($urandom);
        return c;
    endfunction

    // Expected report contents: read data only for error-free reads, read1
    // carries one byte.
    task automatic schedule_report(input logic ack, input logic tmo, input logic [15:0] rd);
        report_at = cyc + 1;
        tx_k      = int'($urandom_range(1, 8));
        e_toaddr  = m_addr;
        e_tomode  = {ack, tmo, m_src_poll, 3'b000, m_mode[1:0]};
        case (m_mode[1:0])
            2'b00:   e_todata = {8'h00, rd[7:0]};
            2'b01:   e_todata = rd;
            default: e_todata = 16'h0000;
        endcase
        if (ack || tmo) e_todata = 16'h0000;
    endtask

    initial begin
        bit   rst_now;
        bit   grant;
        bit   gpoll;
        bit   in_wait;
        bit   in_tx;

        reset         = 1'b1;
        pc_req        = 1'b0;
        pc_address    = 8'h00;
        pc_mode       = 8'h00;
        pc_wdata      = 16'h0000;
        i2c_done      = 1'b0;
        i2c_rdata     = 16'h0000;
        i2c_ack_error = 1'b0;
        tx_complete   = 1'b0;
        pc_hold       = 1'b0;
        force_tx      = 1'b0;
        post_rst      = 1'b1;
        want_rst_wait = 1'b0;
        want_rst_tx   = 1'b0;
        tx_k          = 1;

        // Directed opening: read2, NACKed write1, timeout with a late done,
        // then a burst that exercises the one-entry buffer back-pressure.
        cmdq.push_back('{8'h00, 8'h01, 16'h0000});
        respq.push_back('{3, 16'h1A80, 1'b0});
        cmdq.push_back('{8'h48, 8'h02, 16'h0055});
        respq.push_back('{5, 16'hBEEF, 1'b1});
        cmdq.push_back('{8'h5A, 8'hFD, 16'h1234});
        respq.push_back('{18, 16'h7777, 1'b0});
        cmdq.push_back('{8'h11, 8'h03, 16'hA55A});
        respq.push_back('{16, 16'hC3C3, 1'b0});
        cmdq.push_back('{8'h22, 8'h00, 16'h0000});
        respq.push_back('{2, 16'h99AB, 1'b0});
        cmdq.push_back('{8'h33, 8'h01, 16'hFFFF});
        respq.push_back('{16, 16'h4321, 1'b1});

        @(posedge clk);
        #1;
        model_reset();

        for (cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc == 1000) want_rst_wait = 1'b1;
            if (cyc == 1500) want_rst_tx = 1'b1;

            in_wait = m_busy && start_at >= 0 && cyc > start_at && report_at < 0;
            in_tx   = m_busy && report_at >= 0 && cyc > report_at;

            rst_now = 1'b0;
            if (cyc < 3) begin
                rst_now = 1'b1;
            end else if (want_rst_wait && in_wait) begin
                rst_now       = 1'b1;
                want_rst_wait = 1'b0;
            end else if (want_rst_tx && in_tx) begin
                rst_now     = 1'b1;
                want_rst_tx = 1'b0;
            end else if (cyc > 3000 && $urandom_range(0, 999) < 2) begin
                rst_now = 1'b1;
            end
            reset = rst_now;
            #1;

            if (post_rst) begin
                chk("rst_i2c_address", i2c_address, 8'h00);
                chk("rst_i2c_mode", i2c_mode, 8'h00);
                chk("rst_i2c_wdata", i2c_wdata, 16'h0000);
                chk("rst_toPC_address", toPC_address, 8'h00);
                chk("rst_toPC_mode", toPC_mode, 8'h00);
                chk("rst_toPC_data", toPC_data, 16'h0000);
                chk("rst_pc_ready", pc_ready, 1'b1);
                post_rst = 1'b0;
            end
            chk("i2c_start", i2c_start, !rst_now && cyc == start_at);
            chk("data_ready", data_ready, !rst_now && cyc == report_at);
            chk("pc_ready", pc_ready, !m_buf_valid);
            if (m_busy && start_at >= 0 && cyc >= start_at && (report_at < 0 || cyc < report_at)) begin
                chk("i2c_address", i2c_address, m_addr);
                chk("i2c_mode", i2c_mode, m_mode);
                chk("i2c_wdata", i2c_wdata, m_wdata);
            end
            if (m_busy && report_at >= 0 && cyc >= report_at) begin
                chk("toPC_address", toPC_address, e_toaddr);
                chk("toPC_mode", toPC_mode, e_tomode);
                chk("toPC_data", toPC_data, e_todata);
            end

            // PC requester holds its request until the model says it was taken.
            if (cyc >= 200 && cmdq.size() < 2 && $urandom_range(0, 19) == 0) cmdq.push_back(rand_cmd());
            if (!pc_hold && cmdq.size() > 0 && $urandom_range(0, 3) != 0) pc_hold = 1'b1;
            pc_req = pc_hold;
            if (pc_hold) begin
                pc_address = cmdq[0].addr;
                pc_mode    = cmdq[0].mode;
                pc_wdata   = cmdq[0].wdata;
            end else begin
                pc_address = 8'($urandom);
                pc_mode    = 8'($urandom);
                pc_wdata   = 16'($urandom);
            end

            // I2C master responder, with stray done pulses outside WAIT.
            i2c_done      = 1'b0;
            i2c_rdata     = 16'($urandom);
            i2c_ack_error = ($urandom_range(0, 1) == 1);
            if (m_busy && start_at >= 0 && cyc == start_at + cur_resp.k) begin
                i2c_done      = 1'b1;
                i2c_rdata     = cur_resp.rdata;
                i2c_ack_error = cur_resp.ack;
            end else if (!in_wait && $urandom_range(0, 29) == 0) begin
                i2c_done = 1'b1;
            end

            // Transmitter, with stray completions outside TXWAIT.
            tx_complete = 1'b0;
            if (force_tx) begin
                tx_complete = 1'b1;
                force_tx    = 1'b0;
            end else if (in_tx && cyc == report_at + tx_k) begin
                tx_complete = 1'b1;
            end else if (!in_tx && $urandom_range(0, 19) == 0) begin
                tx_complete = 1'b1;
            end

            // Advance the model by one cycle.
            if (rst_now) begin
                model_reset();
                post_rst = 1'b1;
                force_tx = 1'b1;
            end else begin
                grant = !m_busy && (m_buf_valid || m_flag);
                gpoll = grant && m_flag && !(m_buf_valid && m_last_poll);
                if (in_wait) begin
                    if (i2c_done) schedule_report(i2c_ack_error, 1'b0, i2c_rdata);
                    else if (cyc == start_at + TMO) schedule_report(1'b0, 1'b1, 16'h0000);
                end
                if (in_tx && tx_complete) m_busy = 1'b0;
                if (grant) begin
                    m_src_poll  = gpoll;
                    m_last_poll = gpoll;
                    if (gpoll) begin
                        m_addr  = 8'h00;
                        m_mode  = 8'h01;
                        m_wdata = 16'h0000;
                    end else begin
                        m_addr  = m_buf.addr;
                        m_mode  = {6'b000000, m_buf.mode[1:0]};
                        m_wdata = m_buf.wdata;
                    end
                    start_at  = cyc + 1;
                    report_at = -1;
                    m_busy    = 1'b1;
                    cur_resp  = (respq.size() > 0) ? respq.pop_front() : rand_resp();
                end
                if (grant && !gpoll) begin
                    m_buf_valid = 1'b0;
                end else if (pc_req && !m_buf_valid) begin
                    m_buf_valid = 1'b1;
                    m_buf       = cmdq.pop_front();
                    pc_hold     = 1'b0;
                end
`ifdef AUTO_POLL_EN
                if ((r % P) == P - 1) m_flag = 1'b1;
                else if (gpoll) m_flag = 1'b0;
`endif
                r++;
            end

            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_request_arbiter.md
Name: i2c_request_arbiter

Overview:
Schedules every I2C transaction and its UART report to the PC. Two requesters share one path: decoded PC commands and an internal periodic temperature poll. The path is I2C master → result capture → UART packet transmitter. Only one transaction is in flight at a time. A new grant is issued only after the transmitter asserts tx_complete.

Parameters:
POLL_PERIOD, 50_000_000, clock cycles between auto-poll requests (1 s at 50 MHz)
POLL_ADDR, 8'h00, sensor register address read by the auto-poll
POLL_MODE, 8'h01, mode byte for the auto-poll (two-byte read)
TIMEOUT_CYCLES, 1_000_000, maximum cycles to wait for i2c_done before aborting

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pc_req  in  1  PC command valid
pc_ready  out  1  command buffer empty; command accepted when pc_req && pc_ready
pc_address  in  8  target register address
pc_mode  in  8  op in [1:0]: 00 read1, 01 read2, 10 write1, 11 write2
pc_wdata  in  16  write data (low byte first)
i2c_start  out  1  one-cycle pulse launching an I2C transaction
i2c_address  out  8  held stable from i2c_start until i2c_done/timeout
i2c_mode  out  8  as above
i2c_wdata  out  16  as above
i2c_done  in  1  one-cycle pulse: I2C transaction finished
i2c_rdata  in  16  read data, valid with i2c_done
i2c_ack_error  in  1  NACK seen, valid with i2c_done
data_ready  out  1  one-cycle pulse to the UART packet transmitter
toPC_address  out  8  held stable from data_ready until tx_complete
toPC_mode  out  8  status/mode byte (format below)
toPC_data  out  16  read result, 0 on error or write
tx_complete  in  1  transmitter finished the stop byte

Behaviour:
- Reset values: all outputs 0 except pc_ready=1. Buffer empty, poll flag clear, poll counter 0, last-grant = poll. State IDLE.
- Reset mid-operation aborts everything. The buffered command is dropped. No pulse is emitted in the reset cycle.
- PC buffer: one entry. It loads on pc_req && pc_ready in any state, so a new command can arrive while another is in flight. pc_ready = !buffer_valid (registered). The buffer clears on the cycle it is granted.
- Poll counter: free-runs 0..POLL_PERIOD-1 and wraps.
  - At wrap, the poll flag is set. A second wrap while set does not accumulate.
  - The flag clears when granted.
- States:
  - IDLE: if only one requester is pending, grant it. If both are pending, grant the one not granted last (round-robin). The grant latches address/mode/wdata/source and moves to ISSUE on the next cycle. Grant latency is 1 cycle from a pending request.
  - ISSUE: assert i2c_start for 1 cycle; clear timeout counter; go to WAIT.
  - WAIT: count cycles.
    - On i2c_done: capture rdata and ack_error; go to REPORT.
    - On count == TIMEOUT_CYCLES-1 without i2c_done: set timeout status, force data 0, go to REPORT.
    - i2c_done in the same cycle as the timeout: done wins.
  - REPORT: drive toPC_* and pulse data_ready for 1 cycle; go to TXWAIT.
  - TXWAIT: on tx_complete go to IDLE. The next grant can occur in the IDLE cycle that follows.
- toPC_mode = {ack_error, timeout, source(1=poll), 3'b000, mode[1:0]}.
- toPC_data = captured rdata for read ops without error; otherwise 16'h0000. For read1, only [7:0] is meaningful and [15:8]=0.
- Stray events are ignored: i2c_done outside WAIT and tx_complete outside TXWAIT.
- pc_mode[7:2] is ignored (treated as 0).

Optional Feature:
AUTO_POLL_EN
- Defined: poll counter, poll flag and round-robin arbitration as above.
- Undefined: no counter and no flag. Only PC commands are served. toPC_mode[5] is always 0.

Test Plan:
- PC read2: pc_req addr 8'h00 mode 8'h01 → i2c_start 1 cycle after IDLE grant. i2c_done rdata 16'h1A80 → data_ready pulse, toPC_mode 8'h01, toPC_data 16'h1A80; tx_complete → IDLE, pc_ready=1.
- NACK on write1: mode 8'h02, wdata 16'h0055, i2c_done with ack_error=1 → toPC_mode 8'h82, toPC_data 16'h0000.
- Timeout: TIMEOUT_CYCLES=16, no i2c_done → data_ready exactly 17 cycles after i2c_start (16 WAIT cycles, then the REPORT cycle asserts data_ready), toPC_mode 8'h41; a late i2c_done is ignored.
- Arbitration (AUTO_POLL_EN, POLL_PERIOD=100): PC command and poll pending together, last grant = poll → PC served first, then poll with toPC_address 8'h00, toPC_mode 8'h21; a third wrap during service sets the flag only once.
- Back-pressure: second pc_req during WAIT is accepted and pc_ready drops. A third pc_req is held off until the second is granted, and its fields are issued unchanged.
- Reset asserted in WAIT and in TXWAIT → next cycle all outputs 0, pc_ready=1, no data_ready; a following tx_complete is ignored.
